// File: rtl/stream_mux_rr.sv
// N-channel packet stream mux with a single registered output stage.
// Channel choice is per packet: fixed select or round-robin, held by a packet lock.
module stream_mux_rr #(
    parameter int unsigned N_CH   = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   mode_i,
    input  logic [SEL_W-1:0]       sel_i,
    input  logic [N_CH*DATA_W-1:0] in_data_i,
    input  logic [N_CH-1:0]        in_valid_i,
    input  logic [N_CH-1:0]        in_last_i,
    output logic [N_CH-1:0]        in_ready_o,
    output logic [DATA_W-1:0]      out_data_o,
    output logic                   out_last_o,
    output logic [SEL_W-1:0]       out_ch_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i
);

    logic [DATA_W-1:0] out_data_q;
    logic              out_last_q;
    logic [SEL_W-1:0]  out_ch_q;
    logic              out_valid_q;
    logic              lock_q;
    logic [SEL_W-1:0]  lock_ch_q;
    logic [SEL_W-1:0]  ptr_q;

    logic              load;
    logic              accept;
    logic              sel_in_range;
    logic              rr_valid;
    logic [SEL_W-1:0]  rr_ch;
    logic              grant_valid;
    logic [SEL_W-1:0]  grant_ch;
    logic [DATA_W-1:0] grant_data;
    logic              grant_last;

    // Out-of-range select values only exist when N_CH is not a power of two.
    if (N_CH == (1 << SEL_W)) begin : g_sel_pow2
        assign sel_in_range = 1'b1;
    end else begin : g_sel_npow2
        assign sel_in_range = (32'(sel_i) < N_CH);
    end

    // Search ptr+1 .. ptr+N_CH modulo N_CH, so ptr itself has lowest priority.
    always_comb begin
        int unsigned idx;
        rr_valid = 1'b0;
        rr_ch    = '0;
        idx      = 0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!rr_valid && in_valid_i[SEL_W'(idx)]) begin
                rr_valid = 1'b1;
                rr_ch    = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        grant_ch    = '0;
        grant_valid = 1'b0;
        if (lock_q) begin
            grant_ch    = lock_ch_q;
            grant_valid = in_valid_i[lock_ch_q];
        end else if (mode_i) begin
            grant_ch    = rr_ch;
            grant_valid = rr_valid;
        end else begin
            grant_ch    = sel_i;
            grant_valid = sel_in_range && in_valid_i[sel_i];
        end
    end

    always_comb begin
        grant_data = '0;
        grant_last = 1'b0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (grant_ch == SEL_W'(c)) begin
                grant_data = in_data_i[c*DATA_W +: DATA_W];
                grant_last = in_last_i[c];
            end
        end
    end

    assign load   = ~out_valid_q | out_ready_i;
    assign accept = rst_ni & load & grant_valid;

    always_comb begin
        in_ready_o = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            in_ready_o[c] = accept && (grant_ch == SEL_W'(c));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
            ptr_q       <= SEL_W'(N_CH - 1);
        end else if (accept) begin
            out_data_q  <= grant_data;
            out_last_q  <= grant_last;
            out_ch_q    <= grant_ch;
            out_valid_q <= 1'b1;
            lock_q      <= ~grant_last;
            lock_ch_q   <= grant_ch;
            if (grant_last && mode_i) begin
                ptr_q <= grant_ch;
            end
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_ch_o    = out_ch_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (16 channels, 8-bit beats) with hand-computed expectations.
module tb_stream_mux_rr;

    localparam int unsigned N_CH   = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 4;

    logic                   clk;
    logic                   rst_n;
    logic                   mode;
    logic [SEL_W-1:0]       sel;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_valid;
    logic [N_CH-1:0]        in_last;
    logic [N_CH-1:0]        in_ready;
    logic [DATA_W-1:0]      out_data;
    logic                   out_last;
    logic [SEL_W-1:0]       out_ch;
    logic                   out_valid;
    logic                   out_ready;

    int n_cmp = 0;
    int n_err = 0;

    stream_mux_rr #(
        .N_CH  (N_CH),
        .DATA_W(DATA_W)
    ) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .mode_i     (mode),
        .sel_i      (sel),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_last_i  (in_last),
        .in_ready_o (in_ready),
        .out_data_o (out_data),
        .out_last_o (out_last),
        .out_ch_o   (out_ch),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int c, input logic [7:0] v);
        in_data[c*DATA_W +: DATA_W] = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard for the backpressure section.
    logic [7:0] sb_q[$];
    logic       ordy_pat[12] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    logic       mseq[4] = '{0, 0, 1, 0};
    logic [3:0] sseq[4] = '{2, 1, 0, 1};
    int         rr_exp[6] = '{0, 3, 15, 0, 3, 15};

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = '0;
        in_valid  = '1;
        in_last   = '1;
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) set_data(c, 8'(8'h10 + c));

        // Reset with every channel valid.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_ch", 64'(out_ch), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'h0001);
        step();
        check("rel_out_valid", 64'(out_valid), 64'd1);
        check("rel_out_ch", 64'(out_ch), 64'd0);
        check("rel_out_data", 64'(out_data), 64'h10);
        in_valid = '0;
        step();
        check("idle_out_valid", 64'(out_valid), 64'd0);

        // Fixed select on channel 5 with channel 0 also valid.
        mode     = 1'b0;
        sel      = 4'd5;
        in_valid = 16'h0021;
        set_data(5, 8'hA5);
        #1;
        check("fix_in_ready", 64'(in_ready), 64'h0020);
        step();
        check("fix_out_data", 64'(out_data), 64'hA5);
        check("fix_out_ch", 64'(out_ch), 64'd5);
        check("fix_out_last", 64'(out_last), 64'd1);
        in_valid = '0;
        step();

        // Round-robin among ch0, ch3, ch15 after a reset pulse restores ptr.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        mode     = 1'b1;
        in_last  = '1;
        in_valid = 16'h8009;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_out_valid", 64'(out_valid), 64'd1);
            check("rr_out_ch", 64'(out_ch), 64'(rr_exp[i]));
        end
        in_valid = '0;
        step();

        // Packet lock: 4-beat packet on ch2, ch1 waiting, mode/sel toggling.
        set_data(1, 8'h11);
        for (int i = 0; i < 4; i++) begin
            mode     = mseq[i];
            sel      = sseq[i];
            in_valid = 16'h0006;
            in_last  = (i == 3) ? 16'h0006 : 16'h0002;
            set_data(2, 8'(8'hC0 + i));
            #1;
            check("lock_in_ready", 64'(in_ready), 64'h0004);
            step();
            check("lock_out_data", 64'(out_data), 64'(8'hC0 + i));
            check("lock_out_ch", 64'(out_ch), 64'd2);
            check("lock_out_last", 64'(out_last), 64'(i == 3));
        end
        mode     = 1'b0;
        sel      = 4'd1;
        in_valid = 16'h0002;
        #1;
        check("unlock_in_ready", 64'(in_ready), 64'h0002);
        step();
        check("unlock_out_ch", 64'(out_ch), 64'd1);
        check("unlock_out_data", 64'(out_data), 64'h11);
        in_valid = '0;
        step();

        // Backpressure: 5-beat packet on ch4 with a 3-cycle stall.
        begin
            int         k;
            logic       acc;
            logic [7:0] held;
            k    = 0;
            held = '0;
            mode = 1'b1;
            for (int cyc = 0; cyc < 12; cyc++) begin
                out_ready = ordy_pat[cyc];
                in_valid  = (k < 5) ? 16'h0010 : 16'h0000;
                in_last   = (k == 4) ? 16'h0010 : 16'h0000;
                set_data(4, 8'(8'h40 + k));
                #1;
                acc = in_valid[4] & in_ready[4];
                if (!out_ready && out_valid) begin
                    check("bp_in_ready", 64'(in_ready), 64'd0);
                    check("bp_hold_data", 64'(out_data), 64'(held));
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("bp_extra_beat", 64'(out_data), 64'hFFFF);
                    end else begin
                        check("bp_drain_data", 64'(out_data), 64'(sb_q[0]));
                        check("bp_drain_ch", 64'(out_ch), 64'd4);
                        void'(sb_q.pop_front());
                    end
                end
                if (acc) begin
                    sb_q.push_back(8'(8'h40 + k));
                    k++;
                end
                held = out_data;
                step();
                if (acc) held = 8'(8'h40 + k - 1);
            end
            check("bp_beats_sent", 64'(k), 64'd5);
            check("bp_sb_empty", 64'(sb_q.size()), 64'd0);
            out_ready = 1'b1;
            in_valid  = '0;
            step();
        end

        // Async reset in the middle of a 4-beat ch6 packet.
        mode     = 1'b1;
        in_valid = 16'h0042;
        in_last  = 16'h0002;
        set_data(6, 8'h60);
        #1;
        check("ar_in_ready", 64'(in_ready), 64'h0040);
        step();
        set_data(6, 8'h61);
        step();
        check("ar_out_data", 64'(out_data), 64'h61);
        check("ar_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("ar_drop_valid", 64'(out_valid), 64'd0);
        check("ar_drop_data", 64'(out_data), 64'd0);
        check("ar_rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check("ar_post_in_ready", 64'(in_ready), 64'h0002);

        // Fixed select on an idle channel stalls everyone.
        mode = 1'b0;
        sel  = 4'd9;
        #1;
        check("stall_in_ready", 64'(in_ready), 64'd0);
        sel = 4'd6;
        #1;
        check("fix6_in_ready", 64'(in_ready), 64'h0040);
        in_valid = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel streaming multiplexer: the successor to the fixed 16:1 single-bit select mux. Each of `N_CH` input channels carries `DATA_W`-bit beats with valid/ready/last handshakes. The block selects one channel per packet, either by an explicit `sel` input or by round-robin arbitration, and drives it into a single registered output stage. It sits between multiple packet producers and one shared downstream consumer.

## Interface
- `N_CH`, 16, number of input channels (2..64)
- `DATA_W`, 8, beat width in bits (1..256)
- `SEL_W`, derived = clog2(`N_CH`), width of `sel`/`out_ch`; not overridden
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- `mode`  in  1  0 = fixed select via `sel`, 1 = round-robin
- `sel`  in  SEL_W  channel index used in fixed mode
- `in_data`  in  N_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- `in_valid`  in  N_CH  per-channel beat valid
- `in_last`  in  N_CH  per-channel end-of-packet marker
- `in_ready`  out  N_CH  per-channel accept; at most one bit high per cycle
- `out_data`  out  DATA_W  registered beat
- `out_last`  out  1  registered end-of-packet
- `out_ch`  out  SEL_W  source channel of the current output beat
- `out_valid`  out  1  output beat present
- `out_ready`  in  1  downstream accept

## Operation
- Output stage: one register (data, last, ch, valid). `load = ~out_valid | out_ready`.
- Grant, when unlocked:
  - Fixed mode: `g = sel` if `sel < N_CH` and `in_valid[sel]`; otherwise no grant.
  - RR mode: first c with `in_valid[c]`, searching `ptr+1, ptr+2, …` modulo `N_CH` and wrapping `N_CH-1 -> 0`; `ptr` itself is checked last.
- `in_ready[c] = load & grant_valid & (c == g)`. This is combinational from `out_ready`, `in_valid`, `mode` and `sel`.
- Beat accepted on channel c (`in_valid[c] & in_ready[c]`):
  - Output register loads `in_data[c]`, `in_last[c]` and c; `out_valid` <= 1.
- Packet lock:
  - Accepting a beat with `last=0` sets `lock=1` and `lock_ch=c`.
  - While locked, the grant is forced to `lock_ch` regardless of `mode`/`sel`, and other channels see `in_ready=0`.
  - Accepting a beat with `last=1` clears `lock`.
- RR pointer: on an accepted beat with `last=1`, `ptr <= c`. Fairness is at packet level. `ptr` does not change in fixed mode.
- No accept and `out_ready=1`: `out_valid <= 0`. Other output fields hold their last value.
- `out_valid=1` and `out_ready=0`: all output fields hold and every `in_ready` is 0.
- Changes to `mode`/`sel` mid-packet are ignored until the packet ends and take effect on the next grant.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, `out_ch=0`, `lock=0`, `lock_ch=0`, `ptr=N_CH-1` (so channel 0 has first priority).
- Reset mid-packet discards the output beat and the lock immediately (asynchronous). The partial packet is not resumed.
- Latency: input accept in cycle n gives `out_valid` in cycle n+1.
- Throughput: 1 beat/cycle while `out_ready=1`. No bubble between packets from different channels.
- `in_ready` is 0 for every channel during reset.
- Fixed-mode `sel` pointing at an idle channel stalls; other valid channels are not served.
- Non-power-of-two `N_CH`: `sel >= N_CH` gives no grant. RR search never visits indices `>= N_CH`.

## Test plan
- Reset/idle: assert `rst_n=0` with all `in_valid=1` -> all outputs 0 and `in_ready=0`; after release in RR mode, the first beat comes from ch0 with `out_ch=0` one cycle later.
- Fixed select: `N_CH=16`, `mode=0`, `sel=5`, ch5 sends single-beat packet 8'hA5 -> `out_data=A5`, `out_ch=5`, `out_last=1`; `in_ready` is high only on bit 5.
- Round-robin fairness: ch0, ch3 and ch15 continuously valid with 1-beat packets, `out_ready=1` -> `out_ch` sequence 0,3,15,0,3,15, one beat per cycle with no gaps.
- Packet lock: ch2 sends a 4-beat packet while ch1 is valid and `sel` toggles mid-packet -> four consecutive ch2 beats, `out_last` only on the 4th, then ch1 is served.
- Backpressure: hold `out_ready=0` for 3 cycles with `out_valid=1` -> output stable, all `in_ready=0`; on release, one beat drains per cycle and no data is lost or duplicated (scoreboard).
- Async reset mid-packet: pull `rst_n` low after beat 2 of 4 -> `out_valid` drops without a clock edge; after release the lock is clear and `ptr=N_CH-1`.
